// File: rtl/banked_mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | banked_mem_responder                                                   |
// | Four-bank word-interleaved memory with per-bank busy and 2-cycle reads |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module banked_mem_responder #(
    parameter int DW    = 16,
    parameter int AW    = 16,
    parameter int IDX_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          rd_valid,
    output logic          stall,
    output logic [3:0]    busy,
    output logic          err
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int NB    = 4;

    logic [1:0]       w_bank;
    logic [IDX_W-1:0] w_idx;
    logic             w_req;
    logic             w_accept;
    logic [DW-1:0]    w_bank_word [NB];

    logic             s1_valid_d, s1_valid_q;
    logic [DW-1:0]    s1_data_d,  s1_data_q;
    logic             s2_valid_d, s2_valid_q;
    logic [DW-1:0]    s2_data_d,  s2_data_q;

    assign w_bank   = addr[2:1];
    assign w_idx    = addr[3 +: IDX_W];
    assign err      = (rd & wr) | ((rd | wr) & addr[0]);
    assign w_req    = (rd ^ wr) & ~err;
    assign stall    = w_req & busy[w_bank];
    // Nothing is committed while reset is asserted.
    assign w_accept = w_req & ~busy[w_bank] & ~rst;

    generate
        if (AW > 3 + IDX_W) begin : g_unused_addr
            logic w_unused_hi;
            assign w_unused_hi = ^addr[AW-1:3+IDX_W];
        end

        for (genvar b = 0; b < NB; b++) begin : g_bank
            logic [DW-1:0] mem_q [DEPTH];
            logic [1:0]    cnt_d, cnt_q;
            logic          w_sel;

            assign w_sel          = w_accept && (w_bank == 2'(b));
            assign busy[b]        = (cnt_q != 2'd0);
            assign w_bank_word[b] = mem_q[w_idx];

            always_comb begin
                cnt_d = cnt_q;
                if (w_sel) begin
                    cnt_d = 2'd3;
                end else if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= 2'd0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // Array contents are deliberately left out of reset.
            always_ff @(posedge clk) begin
                if (w_sel && wr) begin
                    mem_q[w_idx] <= data_in;
                end
            end
        end
    endgenerate

    always_comb begin
        s1_valid_d = w_accept & rd;
        s1_data_d  = '0;
        if (w_accept && rd) begin
            s1_data_d = w_bank_word[w_bank];
        end
        s2_valid_d = s1_valid_q;
        s2_data_d  = s1_valid_q ? s1_data_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign rd_valid = s2_valid_q;
    assign data_out = s2_data_q;

endmodule
`default_nettype wire

// File: tb/tb_banked_mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_banked_mem_responder                                                |
// | Directed and random traffic checked against a cycle-level memory model |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_banked_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        rd_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    banked_mem_responder #(.DW(16), .AW(16), .IDX_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .stall    (stall),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] data;
    } rd_exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          free_at [4];
    logic [15:0] mem_m [int];
    rd_exp_t     exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, then advance the model.
    task automatic cycle(input logic a_rd, input logic a_wr, input logic [15:0] a_addr,
                         input logic [15:0] a_din, input logic a_rst, output logic o_stalled);
        logic [3:0]  e_busy;
        logic        e_err, e_stall, e_acc, e_vld;
        logic [15:0] e_dout;
        int          bk, key;
        rst = a_rst; rd = a_rd; wr = a_wr; addr = a_addr; data_in = a_din;
        bk  = int'(a_addr[2:1]);
        key = int'(a_addr[10:3]) * 4 + bk;
        for (int b = 0; b < 4; b++) e_busy[b] = (cyc < free_at[b]);
        e_err   = (a_rd && a_wr) || ((a_rd || a_wr) && a_addr[0]);
        e_stall = (a_rd != a_wr) && !e_err && e_busy[bk];
        e_acc   = (a_rd != a_wr) && !e_err && !e_busy[bk] && !a_rst;
        e_vld   = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        e_dout  = e_vld ? exp_q[0].data : 16'h0000;
        @(negedge clk);
        check_eq("err",      {31'd0, err},      {31'd0, e_err});
        check_eq("stall",    {31'd0, stall},    {31'd0, e_stall});
        check_eq("busy",     {28'd0, busy},     {28'd0, e_busy});
        check_eq("rd_valid", {31'd0, rd_valid}, {31'd0, e_vld});
        check_eq("data_out", {16'd0, data_out}, {16'd0, e_dout});
        o_stalled = stall;
        @(posedge clk);
        if (a_rst) begin
            exp_q.delete();
            for (int b = 0; b < 4; b++) free_at[b] = 0;
        end else begin
            if (e_vld) void'(exp_q.pop_front());
            if (e_acc) begin
                free_at[bk] = cyc + 4;
                if (a_wr) mem_m[key] = a_din;
                else      exp_q.push_back('{due: cyc + 2, data: mem_m[key]});
            end
        end
        cyc++;
        #1;
    endtask

    // Hold a request until accepted; report how many cycles it stalled.
    task automatic req(input logic a_rd, input logic a_wr, input logic [15:0] a_addr,
                       input logic [15:0] a_din, output int n_st);
        logic s;
        n_st = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(a_rd, a_wr, a_addr, a_din, 1'b0, s);
            if (!s) return;
            n_st++;
        end
        check_eq("req_accept_timeout", {31'd0, s}, 32'd0);
    endtask

    task automatic idle(input int n);
        logic s;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, s);
    endtask

    initial begin
        logic        s, pending, p_rd, p_wr, p_rst;
        logic [15:0] p_addr, p_din;
        int          n_st, r;
        for (int b = 0; b < 4; b++) free_at[b] = 0;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        @(posedge clk);
        #1;

        // Reset held while a read is requested.
        cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, s);
        cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, s);

        // First access after release is taken immediately.
        req(1'b0, 1'b1, 16'h0010, 16'hBEEF, n_st);
        check_eq("first_access_stall", n_st, 0);
        idle(3);
        req(1'b1, 1'b0, 16'h0010, 16'h0000, n_st);
        check_eq("wr_rd_stall", n_st, 0);
        idle(2);

        // Populate every word the random phase may read.
        for (int i = 0; i < 8; i++)
            for (int b = 0; b < 4; b++)
                if (!(i == 2 && b == 0))
                    req(1'b0, 1'b1, {5'd0, 8'(i), 2'(b), 1'b0}, 16'($urandom), n_st);
        idle(4);

        // Bank conflict on bank 0.
        req(1'b0, 1'b1, 16'h0000, 16'h1357, n_st);
        req(1'b1, 1'b0, 16'h0008, 16'h0000, n_st);
        check_eq("conflict_stalls", n_st, 3);
        idle(4);

        // Pipelined line fill across all four banks.
        for (int b = 0; b < 4; b++) req(1'b0, 1'b1, 16'h0100 + 16'(2 * b), 16'hA000 + 16'(b), n_st);
        idle(4);
        for (int b = 0; b < 4; b++) begin
            req(1'b1, 1'b0, 16'h0100 + 16'(2 * b), 16'h0000, n_st);
            check_eq("fill_stall", n_st, 0);
        end
        idle(5);

        // Illegal requests must leave memory untouched.
        cycle(1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0, s);
        cycle(1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0, s);
        cycle(1'b0, 1'b1, 16'h0011, 16'h5555, 1'b0, s);
        idle(3);
        req(1'b1, 1'b0, 16'h0010, 16'h0000, n_st);
        idle(4);

        // Reset arriving one cycle after a read is accepted.
        req(1'b1, 1'b0, 16'h0002, 16'h0000, n_st);
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, s);
        idle(3);

        // Random traffic; a stalled request is held unchanged.
        pending = 1'b0;
        p_rd = 1'b0; p_wr = 1'b0; p_addr = '0; p_din = '0;
        for (int i = 0; i < 800; i++) begin
            if (!pending) begin
                r      = int'($urandom % 20);
                p_addr = {5'($urandom), 8'($urandom % 8), 2'($urandom), 1'b0};
                p_din  = 16'($urandom);
                p_rd   = (r >= 4 && r < 12) || r == 18;
                p_wr   = (r >= 12 && r < 17) || r == 18;
                if (r == 17) begin
                    p_rd   = 1'b1;
                    p_addr = p_addr | 16'h0001;
                end
            end
            p_rst = ($urandom % 150) == 0;
            cycle(p_rd, p_wr, p_addr, p_din, p_rst, s);
            pending = s;
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
